// File: rtl/stack_queue.sv
// stack_queue: DEPTH-entry storage that acts as a LIFO stack or a FIFO queue.
// The ordering (mode) is latched into mode_q only while the store is empty,
// so the ordering never changes with data present.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   user_push    push request (one operation per high cycle)
//   user_pop     pop request (one operation per high cycle)
//   mode         requested ordering: 0 = LIFO, 1 = FIFO
//   bus_in       push data
//   bus_out      registered popped data, held until the next successful pop
//   ready        one-cycle pulse: bus_out holds a newly popped word
//   overflow     one-cycle pulse: push rejected (full, no pop)
//   underflow    one-cycle pulse: pop rejected (empty)
//   full, empty, almost_full   occupancy flags from the registered count
//   count        current occupancy, 0..DEPTH
//   mode_q       ordering currently in effect
module stack_queue #(
  parameter int DEPTH       = 8,
  parameter int WIDTH       = 6,
  parameter int ALMOST_FULL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   user_push,
  input  logic                   user_pop,
  input  logic                   mode,
  input  logic [WIDTH-1:0]       bus_in,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   ready,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   mode_q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    LIFO = 1'b0,
    FIFO = 1'b1
  } order_t;

  order_t           order;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(ALMOST_FULL));
  assign mode_q      = order;

  // LIFO entries live at mem[0..count-1]; count itself is the top pointer.
  // A push while full is still accepted when a pop frees a slot on the same
  // edge (LIFO replaces the top, FIFO reads before it overwrites).
  always_comb begin
    top_idx = AW'(count - CW'(1));
    do_pop  = user_pop && !empty;
    do_push = user_push && (!full || do_pop);
    if (order == FIFO) begin
      rd_idx = rd_ptr;
      wr_idx = wr_ptr;
    end else begin
      rd_idx = top_idx;
      wr_idx = do_pop ? top_idx : count[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      bus_out   <= '0;
      ready     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      order     <= LIFO;
    end else begin
      ready     <= do_pop;
      overflow  <= user_push && !do_push;
      underflow <= user_pop && empty;
      if (do_pop) begin
        bus_out <= mem[rd_idx];
      end
      if (order == FIFO) begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (empty && !user_push) begin
        order <= order_t'(mode);
      end
    end
  end

endmodule

// File: tb/tb_stack_queue.sv
// Self-checking bench for stack_queue: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_stack_queue;
  localparam int DEPTH = 8;
  localparam int WIDTH = 6;
  localparam int AF    = DEPTH - 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   user_push = 1'b0;
  logic                   user_pop = 1'b0;
  logic                   mode = 1'b0;
  logic [WIDTH-1:0]       bus_in = '0;
  logic [WIDTH-1:0]       bus_out;
  logic                   ready, overflow, underflow, full, empty, almost_full;
  logic [$clog2(DEPTH):0] count;
  logic                   mode_q;

  stack_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ALMOST_FULL(AF)) dut (
    .clk(clk), .reset(reset), .user_push(user_push), .user_pop(user_pop),
    .mode(mode), .bus_in(bus_in), .bus_out(bus_out), .ready(ready),
    .overflow(overflow), .underflow(underflow), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: back of the queue is the LIFO top / FIFO newest.
  int mq[$];
  int m_out = 0, m_ready = 0, m_ovf = 0, m_unf = 0, m_mode = 0;
  bit started = 0;

  always @(posedge clk) begin : model
    int n;
    int d;
    n = mq.size();
    d = int'(bus_in);
    if (reset) begin
      mq.delete();
      m_out = 0; m_ready = 0; m_ovf = 0; m_unf = 0; m_mode = 0;
      started = 1;
    end else begin
      m_ready = 0; m_ovf = 0; m_unf = 0;
      if (user_push && user_pop) begin
        if (n == 0) begin
          mq.push_back(d);
          m_unf = 1;
        end else if (m_mode == 0) begin
          m_out = mq[n-1];
          mq[n-1] = d;
          m_ready = 1;
        end else begin
          m_out = mq.pop_front();
          mq.push_back(d);
          m_ready = 1;
        end
      end else if (user_push) begin
        if (n == DEPTH) m_ovf = 1;
        else mq.push_back(d);
      end else if (user_pop) begin
        if (n == 0) m_unf = 1;
        else begin
          m_out = (m_mode == 1) ? mq.pop_front() : mq.pop_back();
          m_ready = 1;
        end
      end
      if (n == 0 && !user_push) m_mode = int'(mode);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("bus_out", int'(bus_out), m_out);
      chk("ready", int'(ready), m_ready);
      chk("overflow", int'(overflow), m_ovf);
      chk("underflow", int'(underflow), m_unf);
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("almost_full", int'(almost_full), int'(mq.size() >= AF));
      chk("mode_q", int'(mode_q), m_mode);
    end
  end

  logic cur_mode = 1'b0;

  // Drive one cycle of requests; on return the edge has consumed them.
  task automatic cyc(input bit p, input bit pp, input int d);
    user_push = p;
    user_pop  = pp;
    mode      = cur_mode;
    bus_in    = WIDTH'(d);
    @(posedge clk);
    #2;
    user_push = 1'b0;
    user_pop  = 1'b0;
  endtask

  task automatic push(input int d); cyc(1, 0, d); endtask
  task automatic pop();             cyc(0, 1, 0); endtask
  task automatic both(input int d); cyc(1, 1, d); endtask
  task automatic idle();            cyc(0, 0, 0); endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int bias;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_bus_out", int'(bus_out), 0);
    chk("rst_mode_q", int'(mode_q), 0);

    // LIFO fill, overflow, drain
    cur_mode = 1'b0;
    for (int i = 0; i < 8; i++) push(i);
    push(8);
    chk("lifo_ovf", int'(overflow), 1);
    chk("lifo_full_count", int'(count), 8);
    chk("lifo_full", int'(full), 1);
    idle();
    chk("lifo_ovf_single", int'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("lifo_pop", int'(bus_out), 7 - i);
      chk("lifo_ready", int'(ready), 1);
    end
    chk("lifo_empty", int'(empty), 1);

    // FIFO order and underflow
    cur_mode = 1'b1;
    idle();
    chk("mode_fifo", int'(mode_q), 1);
    for (int i = 0; i < 8; i++) push(i);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("fifo_pop", int'(bus_out), i);
    end
    pop();
    chk("fifo_unf", int'(underflow), 1);
    chk("fifo_unf_ready", int'(ready), 0);
    chk("fifo_unf_hold", int'(bus_out), 7);

    // FIFO pointer wrap
    for (int i = 0; i < 6; i++) push(i);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("wrap_pop_a", int'(bus_out), i);
    end
    for (int i = 0; i < 6; i++) push(i);
    chk("wrap_count", int'(count), 8);
    chk("wrap_full", int'(full), 1);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("wrap_pop_b", int'(bus_out), (i < 2) ? i + 4 : i - 2);
    end

    // FIFO full push+pop, then empty push+pop
    for (int i = 0; i < 8; i++) push(30 + i);
    both(50);
    chk("ff_pp_out", int'(bus_out), 30);
    chk("ff_pp_count", int'(count), 8);
    chk("ff_pp_ovf", int'(overflow), 0);
    chk("ff_pp_ready", int'(ready), 1);
    for (int i = 0; i < 8; i++) pop();
    chk("ff_pp_last", int'(bus_out), 50);
    both(20);
    chk("e_pp_unf", int'(underflow), 1);
    chk("e_pp_ready", int'(ready), 0);
    chk("e_pp_count", int'(count), 1);
    pop();
    chk("e_pp_pop", int'(bus_out), 20);

    // LIFO push+pop replaces the top
    cur_mode = 1'b0;
    idle();
    chk("mode_lifo", int'(mode_q), 0);
    push(3);
    push(9);
    both(5);
    chk("l_pp_out", int'(bus_out), 9);
    chk("l_pp_count", int'(count), 2);
    pop();
    chk("l_pp_top", int'(bus_out), 5);

    // Mode lock with data present, then reset mid-operation
    push(1);
    push(2);
    chk("lock_count", int'(count), 3);
    cur_mode = 1'b1;
    idle();
    chk("lock_hold", int'(mode_q), 0);
    repeat (3) pop();
    chk("lock_drained", int'(mode_q), 0);
    idle();
    chk("lock_load", int'(mode_q), 1);
    for (int i = 0; i < 5; i++) push(40 + i);
    chk("pre_rst_count", int'(count), 5);
    pulse_reset();
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_bus_out", int'(bus_out), 0);
    chk("mid_rst_mode_q", int'(mode_q), 0);

    // Randomized traffic, checked every cycle by the model
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = $urandom_range(25, 75);
      if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
      if ($urandom_range(0, 249) == 0) pulse_reset();
      else cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
               int'($urandom_range(0, 63)));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_queue.md
STACK_QUEUE -- requirements
Module: stack_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 6, data word width in bits.
REQ-003 Parameter ALMOST_FULL, default DEPTH-2, occupancy threshold for almost_full; SHALL be in range 1..DEPTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 user_push  input  1  push request, sampled each rising edge.
REQ-007 user_pop  input  1  pop request, sampled each rising edge.
REQ-008 mode  input  1  requested ordering: 0 = LIFO, 1 = FIFO.
REQ-009 bus_in  input  WIDTH  push data.
REQ-010 bus_out  output  WIDTH  registered popped data.
REQ-011 ready  output  1  one-cycle pulse: bus_out holds a newly popped word.
REQ-012 overflow  output  1  one-cycle pulse: push rejected.
REQ-013 underflow  output  1  one-cycle pulse: pop rejected.
REQ-014 full, empty, almost_full  output  1 each  occupancy flags.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 mode_q  output  1  ordering currently in effect.

Function
REQ-017 Each cycle a high request SHALL be one operation; holding a request high for N cycles SHALL perform N operations.
REQ-018 Push, not full: store bus_in, count +1 on the same edge.
REQ-019 Push, full, no pop: data and count unchanged; overflow pulses next cycle.
REQ-020 Pop, not empty: bus_out = top entry (LIFO) or oldest entry (FIFO); count -1; ready pulses in the same cycle bus_out updates, i.e. one-cycle latency.
REQ-021 Pop, empty: bus_out holds its value; count unchanged; underflow pulses; ready stays low.
REQ-022 Push+pop, LIFO, not empty: bus_out = old top; top replaced by bus_in; count unchanged; ready pulses.
REQ-023 Push+pop, FIFO, not empty: oldest word to bus_out, bus_in appended, count unchanged; ready pulses. Also applies when full; overflow stays low.
REQ-024 Push+pop when empty (either mode): push only; underflow pulses; ready stays low; count becomes 1.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH; LIFO uses a top pointer with no wrap.
REQ-026 mode_q SHALL load from mode only on edges where empty is high and no push is requested; otherwise mode_q holds, so ordering never changes with data present.
REQ-027 full = (count == DEPTH); empty = (count == 0); almost_full = (count >= ALMOST_FULL); all derived from registered count.
REQ-028 bus_out SHALL hold its last popped value until the next successful pop.

Reset
REQ-029 While reset is high on a rising edge: count = 0, pointers = 0, bus_out = 0, ready = overflow = underflow = 0, mode_q = 0; user_push and user_pop are ignored.
REQ-030 Resulting flags: empty = 1, full = 0, almost_full = 0 (for ALMOST_FULL >= 1).
REQ-031 Reset mid-operation SHALL discard all stored data; storage array contents need not be cleared.
REQ-032 After reset deasserts, the first request is accepted on the next rising edge.

Verification
REQ-033 LIFO, DEPTH=8, WIDTH=6: push 0..7, then one more push -> full=1, count=8, single overflow pulse; 8 pops -> bus_out 7,6,...,0, each with a ready pulse; then empty=1.
REQ-034 FIFO: push 0..7, pop 8 -> bus_out 0..7 in order; 9th pop -> underflow pulse, bus_out stays 7.
REQ-035 FIFO wrap: push 6, pop 4, push 6 -> count=8, full=1; 8 pops -> 4,5,0..5 with bus_in values applied in push order.
REQ-036 Simultaneous ops: LIFO holding 3,9 with push 5 + pop -> bus_out=9, count=2, top=5. FIFO full with push+pop -> count stays 8, no overflow. Empty with push+pop -> underflow, count=1.
REQ-037 Mode lock: set mode=1 while count=3 -> mode_q stays 0. Drain, then mode=1 -> mode_q=1 on next edge. Reset at count=5 -> count=0, empty=1, bus_out=0, mode_q=0.
